// File: rtl/multicycle_datapath_if.sv
// Instruction and data memory bus for multicycle_datapath.
// master: the core (drives requests); slave: the memory side (drives acks/data).
//   imem_req/imem_addr   fetch request and byte address
//   imem_ack/imem_rdata  fetch acknowledge and 32-bit instruction word
//   dmem_req/dmem_we/dmem_addr/dmem_wdata  data request, write enable, address, write data
//   dmem_ack/dmem_rdata  data acknowledge and read data
interface multicycle_datapath_if #(
  parameter int unsigned DATA_W = 32
);
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with
// register file, single ALU result latch and registered memory requests.
// Ports:
//   Clk       sole clock, rising edge
//   Rst       asynchronous active-low reset
//   bus       memory bus (master side)
//   halted    core stopped (terminal until reset)
//   illegal   the stop was caused by an undecodable instruction
//   dbg_sel   debug register select
//   dbg_data  combinational read of register dbg_sel (0 when out of range)
module multicycle_datapath #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       NREGS    = 32,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  multicycle_datapath_if.master   bus,
  output logic                    halted,
  output logic                    illegal,
  input  logic [4:0]              dbg_sel,
  output logic [DATA_W-1:0]       dbg_data
);

  localparam int unsigned IDX_W = $clog2(NREGS);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t            state;
  logic [DATA_W-1:0] pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, target_q, res_q;
  logic [DATA_W-1:0] rf [NREGS];

  // Instruction fields
  logic [5:0]        op, funct;
  logic [4:0]        shamt;
  logic [IDX_W-1:0]  rs_idx, rt_idx, rd_idx, dst_idx;
  logic [DATA_W-1:0] sext_imm;

  assign op       = ir[31:26];
  assign funct    = ir[5:0];
  assign shamt    = ir[10:6];
  assign rs_idx   = ir[21 +: IDX_W];
  assign rt_idx   = ir[16 +: IDX_W];
  assign rd_idx   = ir[11 +: IDX_W];
  assign sext_imm = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign dst_idx  = (op == OP_R) ? rd_idx : rt_idx;

  // Decode legality
  logic legal_c;
  always_comb begin
    legal_c = 1'b0;
    case (op)
      OP_R: legal_c = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                      (funct == F_OR)  || (funct == F_SLT) || (funct == F_SLL) ||
                      (funct == F_SRL);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal_c = 1'b1;
      default: legal_c = 1'b0;
    endcase
  end

  // R-type ALU; shifts operate on rt as in MIPS
  logic [DATA_W-1:0] alu_r_c;
  always_comb begin
    alu_r_c = '0;
    case (funct)
      F_ADD:   alu_r_c = a_q + b_q;
      F_SUB:   alu_r_c = a_q - b_q;
      F_AND:   alu_r_c = a_q & b_q;
      F_OR:    alu_r_c = a_q | b_q;
      F_SLT:   alu_r_c = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      F_SLL:   alu_r_c = b_q << shamt;
      F_SRL:   alu_r_c = b_q >> shamt;
      default: alu_r_c = '0;
    endcase
  end

  // Debug read port; register 0 and out-of-range selects read as zero
  logic [IDX_W-1:0] dbg_idx;
  assign dbg_idx  = dbg_sel[IDX_W-1:0];
  assign dbg_data = ((32'(dbg_sel) < NREGS) && (dbg_idx != '0)) ? rf[dbg_idx] : '0;

  // Sequencer and datapath registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state          <= FETCH;
      pc             <= PC_RESET;
      ir             <= '0;
      a_q            <= '0;
      b_q            <= '0;
      target_q       <= '0;
      res_q          <= '0;
      halted         <= 1'b0;
      illegal        <= 1'b0;
      bus.imem_req   <= 1'b0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          // Request is low only in the first cycle after reset
          if (!bus.imem_req) begin
            bus.imem_req <= 1'b1;
          end else if (bus.imem_ack) begin
            ir           <= bus.imem_rdata;
            pc           <= pc + DATA_W'(4);
            bus.imem_req <= 1'b0;
            state        <= DECODE;
          end
        end
        DECODE: begin
          a_q      <= rf[rs_idx];
          b_q      <= rf[rt_idx];
          target_q <= pc + {sext_imm[DATA_W-3:0], 2'b00};
          if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (!legal_c) begin
            halted  <= 1'b1;
            illegal <= 1'b1;
            state   <= HALT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          case (op)
            OP_R: begin
              res_q <= alu_r_c;
              state <= WB;
            end
            OP_ADDI: begin
              res_q <= a_q + sext_imm;
              state <= WB;
            end
            OP_LW, OP_SW: begin
              bus.dmem_addr  <= a_q + sext_imm;
              bus.dmem_wdata <= b_q;
              bus.dmem_we    <= (op == OP_SW);
              bus.dmem_req   <= 1'b1;
              state          <= MEM;
            end
            OP_BEQ, OP_BNE: begin
              if ((a_q == b_q) == (op == OP_BEQ)) pc <= target_q;
              bus.imem_req <= 1'b1;
              state        <= FETCH;
            end
            default: begin
              // Only OP_J reaches here after decode
              pc           <= {pc[DATA_W-1:28], ir[25:0], 2'b00};
              bus.imem_req <= 1'b1;
              state        <= FETCH;
            end
          endcase
        end
        MEM: begin
          if (bus.dmem_ack) begin
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
            if (bus.dmem_we) begin
              bus.imem_req <= 1'b1;
              state        <= FETCH;
            end else begin
              res_q <= bus.dmem_rdata;
              state <= WB;
            end
          end
        end
        WB: begin
          if (dst_idx != '0) rf[dst_idx] <= res_q;
          bus.imem_req <= 1'b1;
          state        <= FETCH;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

  assign bus.imem_addr = pc;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath with a behavioural memory responder.
module tb_multicycle_datapath;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        halted, illegal;
  logic [4:0]  dbg_sel = '0;
  logic [31:0] dbg_data;

  multicycle_datapath_if #(.DATA_W(32)) bus ();

  multicycle_datapath #(.DATA_W(32), .NREGS(32), .PC_RESET(32'h0)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .bus      (bus),
    .halted   (halted),
    .illegal  (illegal),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  int          dlat = 0;
  int          dcnt = 0;
  int          cyc  = 0;
  int          both_req = 0;
  int          req_in_halt = 0;
  int          unstable = 0;
  int          nf = 0;
  logic [31:0] fa [64];
  int          fc [64];
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic        p_dreq = 1'b0, p_we = 1'b0;
  logic [31:0] p_daddr = '0, p_wdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Memory responder and protocol monitor; acks are driven mid-cycle
  always @(negedge Clk) begin
    cyc++;
    bus.imem_ack   = bus.imem_req;
    bus.imem_rdata = bus.imem_req ? imem[bus.imem_addr[7:2]] : 32'h0;
    if (bus.dmem_req) begin
      bus.dmem_ack   = (dcnt == dlat);
      bus.dmem_rdata = (dcnt == dlat) ? dmem[bus.dmem_addr[5:2]] : 32'h0;
      if (bus.dmem_ack && bus.dmem_we) begin
        dmem[bus.dmem_addr[5:2]] = bus.dmem_wdata;
        wr_addr = bus.dmem_addr;
        wr_data = bus.dmem_wdata;
      end
      dcnt++;
    end else begin
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = 32'h0;
      dcnt = 0;
    end
    if (Rst) begin
      if (bus.imem_req && bus.dmem_req) both_req++;
      if (halted && (bus.imem_req || bus.dmem_req)) req_in_halt++;
      if (bus.dmem_req && p_dreq &&
          (bus.dmem_addr != p_daddr || bus.dmem_wdata != p_wdata || bus.dmem_we != p_we))
        unstable++;
      if (bus.imem_req && bus.imem_ack && nf < 64) begin
        fa[nf] = bus.imem_addr;
        fc[nf] = cyc;
        nf++;
      end
    end
    p_dreq  = bus.dmem_req;
    p_daddr = bus.dmem_addr;
    p_wdata = bus.dmem_wdata;
    p_we    = bus.dmem_we;
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = {6'h3F, 26'h0};
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
  endtask

  task automatic reset_and_release();
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    nf = 0;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic wait_halt(input int max, output int n);
    n = 0;
    while (n < max) begin
      @(posedge Clk);
      #1;
      n++;
      if (halted) break;
    end
    if (!halted) check("halt_timeout", 32'(n), 32'(max + 1));
  endtask

  task automatic rd_reg(input int idx, output logic [31:0] v);
    dbg_sel = 5'(idx);
    #1;
    v = dbg_data;
  endtask

  logic [31:0] v;
  int          n;

  initial begin
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    clear_mem();

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst_halted",   32'(halted),       32'd0);
    check("rst_illegal",  32'(illegal),      32'd0);
    check("rst_pc",       bus.imem_addr,     32'h0);

    // Zero-wait timing: 3 ALU-class instructions + halt
    imem[0] = itype(6'h08, 0, 8, 5);
    imem[1] = itype(6'h08, 0, 9, -3);
    imem[2] = rtype(8, 9, 10, 0, 6'h20);
    imem[3] = {6'h3F, 26'h0};
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    check("req_after_rst", 32'(bus.imem_req), 32'd1);
    wait_halt(200, n);
    check("halt_cycles", 32'(n + 1), 32'd15);
    rd_reg(10, v); check("add_r10", v, 32'd2);
    check("t1_illegal", 32'(illegal), 32'd0);

    // ALU coverage, store/load with wait states, bne fall-through, jump
    clear_mem();
    dlat = 3;
    imem[0]  = itype(6'h08, 0, 8, 5);
    imem[1]  = itype(6'h08, 0, 9, -3);
    imem[2]  = itype(6'h08, 0, 0, 7);
    imem[3]  = rtype(0, 8, 12, 31, 6'h00);
    imem[4]  = itype(6'h08, 0, 14, -1);
    imem[5]  = itype(6'h08, 0, 15, 1);
    imem[6]  = rtype(14, 15, 13, 0, 6'h2A);
    imem[7]  = rtype(15, 14, 16, 0, 6'h2A);
    imem[8]  = rtype(8, 9, 17, 0, 6'h22);
    imem[9]  = rtype(8, 9, 18, 0, 6'h24);
    imem[10] = rtype(8, 9, 19, 0, 6'h25);
    imem[11] = rtype(0, 9, 20, 28, 6'h02);
    imem[12] = itype(6'h2B, 0, 8, 4);
    imem[13] = itype(6'h23, 0, 11, 4);
    imem[14] = itype(6'h05, 8, 8, 1);
    imem[15] = {6'h02, 26'd17};
    imem[16] = itype(6'h08, 0, 21, 99);
    imem[17] = {6'h3F, 26'h0};
    unstable = 0;
    reset_and_release();
    wait_halt(400, n);
    rd_reg(0, v);  check("r0_zero", v, 32'h0);
    rd_reg(12, v); check("sll31", v, 32'h8000_0000);
    rd_reg(13, v); check("slt_m1_1", v, 32'd1);
    rd_reg(16, v); check("slt_1_m1", v, 32'd0);
    rd_reg(17, v); check("sub", v, 32'd8);
    rd_reg(18, v); check("and", v, 32'd5);
    rd_reg(19, v); check("or", v, 32'hFFFF_FFFD);
    rd_reg(20, v); check("srl", v, 32'h0000_000F);
    check("sw_addr", wr_addr, 32'd4);
    check("sw_data", wr_data, 32'd5);
    rd_reg(11, v); check("lw_r11", v, 32'd5);
    check("mem_stable", 32'(unstable), 32'd0);
    rd_reg(21, v); check("bne_j_skip", v, 32'd0);
    check("j_last_fetch", fa[nf-1], 32'd68);

    // beq self-loop after bne fall-through
    clear_mem();
    dlat = 0;
    imem[0] = itype(6'h08, 0, 8, 5);
    imem[1] = itype(6'h05, 8, 8, 1);
    imem[2] = itype(6'h04, 8, 8, -1);
    reset_and_release();
    repeat (30) @(posedge Clk);
    #1;
    check("loop_nohalt", 32'(halted), 32'd0);
    check("fetch1", fa[1], 32'd4);
    check("fetch2", fa[2], 32'd8);
    check("fetch3", fa[3], 32'd8);
    check("bne_period", 32'(fc[2] - fc[1]), 32'd3);
    check("beq_period", 32'(fc[4] - fc[3]), 32'd3);

    // Illegal opcode
    clear_mem();
    imem[0] = itype(6'h08, 0, 8, 5);
    imem[1] = {6'h3E, 26'h0};
    reset_and_release();
    wait_halt(100, n);
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_halted", 32'(halted), 32'd1);
    repeat (10) @(posedge Clk);
    #1;
    check("ill_no_req", 32'(bus.imem_req), 32'd0);
    check("ill_nfetch", 32'(nf), 32'd2);

    // Reset in the middle of a stalled store
    clear_mem();
    dlat = 1000;
    imem[0] = itype(6'h2B, 0, 0, 0);
    reset_and_release();
    n = 0;
    while (!bus.dmem_req && n < 50) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("mem_req_seen", 32'(bus.dmem_req), 32'd1);
    repeat (2) @(posedge Clk);
    #3;
    Rst = 1'b0;
    #1;
    check("arst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("arst_imem_req", 32'(bus.imem_req), 32'd0);
    check("arst_pc", bus.imem_addr, 32'h0);
    clear_mem();
    dlat = 0;
    imem[0] = itype(6'h08, 0, 8, 9);
    reset_and_release();
    wait_halt(100, n);
    check("restart_fetch0", fa[0], 32'h0);
    rd_reg(8, v); check("restart_r8", v, 32'd9);
    rd_reg(31, v); check("restart_r31", v, 32'h0);

    check("no_dual_req", 32'(both_req), 32'd0);
    check("no_req_halted", 32'(req_in_halt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
